// File: rtl/rc4_ksa_engine_if.sv
// rc4_ksa_engine_if: start/busy/done handshake plus single-port S-memory bus of the RC4 KSA engine
interface rc4_ksa_engine_if #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
);
  logic                   start;
  logic                   fill_en;
  logic [KEY_BYTES*8-1:0] key;
  logic                   busy;
  logic                   done;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ADDR_W-1:0]      mem_wdata;
  logic                   mem_wren;
  logic [ADDR_W-1:0]      mem_rdata;
  modport master (
    output start, fill_en, key, mem_rdata,
    input  busy, done, mem_addr, mem_wdata, mem_wren
  );
  modport slave (
    input  start, fill_en, key, mem_rdata,
    output busy, done, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: optional S[i]=i fill followed by the RC4 key schedule over one single-port RAM port
module rc4_ksa_engine #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rc4_ksa_engine_if.slave   bus
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [3:0] {IDLE, FILL, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE} state_t;
  state_t            state, state_d;
  logic [ADDR_W-1:0] i, j, si, sj, i_d, j_d, si_d, sj_d, kb;
  logic [ADDR_W-1:0] addr_d, wdata_d;
  logic              wren_d, busy_d, done_d;
  logic [KW-1:0]     kidx, kidx_d;
  logic [7:0]        kbytes [2**KW];
  genvar g;
  for (g = 0; g < 2**KW; g++) begin : g_kb
    if (g < KEY_BYTES) begin : g_key
      assign kbytes[g] = bus.key[KEY_BYTES*8-1-8*g -: 8];
    end else begin : g_pad
      assign kbytes[g] = 8'h00;
    end
  end
  assign kb = ADDR_W'(kbytes[kidx]);
  always_comb begin
    state_d = state;
    i_d     = i;
    j_d     = j;
    kidx_d  = kidx;
    si_d    = si;
    sj_d    = sj;
    case (state)
      IDLE: if (bus.start) begin
        state_d = bus.fill_en ? FILL : RD_I;
        i_d     = '0;
        j_d     = '0;
        kidx_d  = '0;
      end
      FILL: begin
        i_d     = i + ADDR_W'(1);
        state_d = &i ? RD_I : FILL;
      end
      RD_I:  state_d = LAT_I;
      LAT_I: begin
        si_d    = bus.mem_rdata;
        j_d     = j + bus.mem_rdata + kb;
        state_d = RD_J;
      end
      RD_J:  state_d = LAT_J;
      LAT_J: begin
        sj_d    = bus.mem_rdata;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: if (&i) state_d = DONE;
      else begin
        i_d     = i + ADDR_W'(1);
        kidx_d  = kidx == KW'(KEY_BYTES-1) ? '0 : kidx + KW'(1);
        state_d = RD_I;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered for the state being entered, so the RAM sees them during that state
    addr_d  = (state_d == RD_J || state_d == WR_J) ? j_d : i_d;
    wdata_d = state_d == FILL ? i_d : state_d == WR_I ? sj_d : si_d;
    wren_d  = state_d == FILL || state_d == WR_I || state_d == WR_J;
    busy_d  = state_d != IDLE && state_d != DONE;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      kidx          <= '0;
      si            <= '0;
      sj            <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wren  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_d;
      i             <= i_d;
      j             <= j_d;
      kidx          <= kidx_d;
      si            <= si_d;
      sj            <= sj_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      bus.mem_wren  <= wren_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
    end
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine: scoreboard bench for a 4-entry and a 256-entry KSA engine with behavioural RAMs
module tb_rc4_ksa_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rc4_ksa_engine_if #(.KEY_BYTES(1), .ADDR_W(2)) ia();
  rc4_ksa_engine_if #(.KEY_BYTES(3), .ADDR_W(8)) ib();
  rc4_ksa_engine #(.KEY_BYTES(1), .ADDR_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  logic [1:0] ram_a [4];
  logic [7:0] ram_b [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_a = 8'h00, ld_d = 8'h00;
  always @(posedge clk)
    if (ia.mem_wren) ram_a[ia.mem_addr] <= ia.mem_wdata;
    else ia.mem_rdata <= ram_a[ia.mem_addr];
  always @(posedge clk)
    if (ld_en) ram_b[ld_a] <= ld_d;
    else if (ib.mem_wren) ram_b[ib.mem_addr] <= ib.mem_wdata;
    else ib.mem_rdata <= ram_b[ib.mem_addr];
  int cyc = 0, wr_a = 0, wr_b = 0, bsy_a = 0, bsy_b = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    wr_a  <= wr_a + (ia.mem_wren ? 1 : 0);
    wr_b  <= wr_b + (ib.mem_wren ? 1 : 0);
    bsy_a <= bsy_a + (ia.busy ? 1 : 0);
    bsy_b <= bsy_b + (ib.busy ? 1 : 0);
  end
  typedef struct {
    string          nm;
    int             lat;
    int             wr;
    int             bsy;
    int             n;
    logic [2047:0]  mem;
  } exp_t;
  exp_t qa[$], qb[$];
  int acc_a = 0, acc_b = 0, wr0_a = 0, wr0_b = 0, b0_a = 0, b0_b = 0;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_done(input exp_t e, input int lat, input int wr, input int bsy, input logic [2047:0] act);
    int bad;
    chk({e.nm, "_done_cycle"}, lat, e.lat);
    chk({e.nm, "_writes"}, wr, e.wr);
    chk({e.nm, "_busy_cycles"}, bsy, e.bsy);
    bad = -1;
    for (int k = e.n - 1; k >= 0; k--) if (act[8*k +: 8] != e.mem[8*k +: 8]) bad = k;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_mem: S[%0d] got %0d expected %0d", e.nm, bad, act[8*bad +: 8], e.mem[8*bad +: 8]);
    end
  endtask
  always @(negedge clk) begin
    logic [2047:0] act;
    if (!rst_n) begin
      chk("reset_a_outputs", {ia.mem_addr, ia.mem_wdata, ia.mem_wren, ia.busy, ia.done}, 0);
      chk("reset_b_outputs", {ib.mem_addr, ib.mem_wdata, ib.mem_wren, ib.busy, ib.done}, 0);
    end else begin
      if (ia.done) begin
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          act = '0;
          for (int k = 0; k < 4; k++) act[8*k +: 8] = {6'b0, ram_a[k]};
          check_done(qa.pop_front(), cyc - acc_a + 1, wr_a - wr0_a, bsy_a - b0_a, act);
        end
      end else if (qa.size() > 0 && cyc - acc_a > 4000) begin
        chk("a_done_timeout", 0, 1);
        void'(qa.pop_front());
      end
      if (ib.done) begin
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          act = '0;
          for (int k = 0; k < 256; k++) act[8*k +: 8] = ram_b[k];
          check_done(qb.pop_front(), cyc - acc_b + 1, wr_b - wr0_b, bsy_b - b0_b, act);
        end
      end else if (qb.size() > 0 && cyc - acc_b > 4000) begin
        chk("b_done_timeout", 0, 1);
        void'(qb.pop_front());
      end
    end
  end
  function automatic logic [2047:0] ident();
    logic [2047:0] s = '0;
    for (int k = 0; k < 256; k++) s[8*k +: 8] = 8'(k);
    return s;
  endfunction
  function automatic logic [2047:0] perm();
    logic [2047:0] s = '0;
    for (int k = 0; k < 256; k++) s[8*k +: 8] = 8'(k * 37 + 11);
    return s;
  endfunction
  function automatic logic [2047:0] ksa(input logic [2047:0] s0, input logic [23:0] key);
    int s[256];
    int j, t;
    logic [2047:0] r = '0;
    for (int k = 0; k < 256; k++) s[k] = int'(s0[8*k +: 8]);
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(key[8*(2 - k % 3) +: 8])) & 255;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) r[8*k +: 8] = 8'(s[k]);
    return r;
  endfunction
  task automatic go_a(input logic fill, input logic [7:0] k, input exp_t e);
    @(negedge clk);
    ia.start = 1'b1; ia.fill_en = fill; ia.key = k;
    @(negedge clk);
    ia.start = 1'b0;
    acc_a = cyc; wr0_a = wr_a; b0_a = bsy_a;
    qa.push_back(e);
    while (qa.size() != 0) @(negedge clk);
  endtask
  task automatic go_b(input logic fill, input logic [23:0] k, input exp_t e, input bit push);
    @(negedge clk);
    ib.start = 1'b1; ib.fill_en = fill; ib.key = k;
    @(negedge clk);
    ib.start = 1'b0;
    acc_b = cyc; wr0_b = wr_b; b0_b = bsy_b;
    if (push) qb.push_back(e);
  endtask
  task automatic wait_b();
    while (qb.size() != 0) @(negedge clk);
  endtask
  task automatic wait_rel(input int e);
    while (cyc < acc_b + e) @(negedge clk);
  endtask
  task automatic pulse_b();
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic [2047:0] ea;
    logic [23:0]   k3, k4;
    ea = {2016'b0, 8'd1, 8'd3, 8'd2, 8'd0};
    k3 = 24'h000249;
    k4 = 24'hA55A3C;
    ia.start = 1'b0; ia.fill_en = 1'b0; ia.key = '0;
    ib.start = 1'b0; ib.fill_en = 1'b0; ib.key = '0;
    repeat (3) @(negedge clk);
    @(posedge clk) #2 rst_n = 1'b1;
    go_a(1'b1, 8'h00, '{"t1_key00", 29, 12, 28, 4, ea});
    go_a(1'b1, 8'h04, '{"t2_key04", 29, 12, 28, 4, ea});
    go_b(1'b1, k3, '{"t3_fill", 1793, 768, 1792, 256, ksa(ident(), k3)}, 1'b1);
    wait_b();
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_a = 8'(k); ld_d = 8'(k * 37 + 11);
    end
    @(negedge clk) ld_en = 1'b0;
    go_b(1'b0, k4, '{"t4_nofill", 1537, 512, 1536, 256, ksa(perm(), k4)}, 1'b1);
    wait_b();
    go_b(1'b1, k3, '{"t5_start_busy", 1793, 768, 1792, 256, ksa(ident(), k3)}, 1'b1);
    wait_rel(256 + 2);       pulse_b();
    wait_rel(256 + 600 + 2); pulse_b();
    wait_rel(256 + 1530 + 2); pulse_b();
    wait_rel(1792);          pulse_b();
    wait_b();
    repeat (4) @(negedge clk);
    go_b(1'b1, k3, '{"t6_aborted", 0, 0, 0, 256, '0}, 1'b0);
    wait_rel(559);
    @(posedge clk) #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk) #2 rst_n = 1'b1;
    go_b(1'b1, k3, '{"t6_after_reset", 1793, 768, 1792, 256, ksa(ident(), k3)}, 1'b1);
    wait_b();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
